// File: rtl/uart_calc_parser.sv
// ASCII calculator parser for "<A><op><B><term>" byte streams from the UART RX stage.
// Produces a registered result with a one-cycle valid pulse, or a one-cycle err pulse.
module uart_calc_parser #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned MAX_DIGITS = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             ovf,
  output logic             err,
  output logic             busy
);

  localparam int unsigned CW = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0] MaxCnt = CW'(MAX_DIGITS);

  typedef enum logic [1:0] {StIdle, StOpa, StOpb0, StOpb} state_t;
  typedef enum logic [1:0] {OpAdd, OpSub, OpMul} op_t;

  state_t          state;
  op_t             op;
  logic [WIDTH-1:0] opa, opb;
  logic [CW-1:0]   dcnt;

  logic             is_digit, is_op, is_term, is_space, is_err, room;
  logic [WIDTH-1:0] digit, acc_a, acc_b, diff;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH-1:0] prod;
  op_t              op_in;

  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_op    = (rx_data == 8'h2B) || (rx_data == 8'h2D) || (rx_data == 8'h2A);
  assign is_term  = (rx_data == 8'h3D) || (rx_data == 8'h0D);
  assign is_space = (rx_data == 8'h20);
  assign room     = (dcnt < MaxCnt);

  assign digit = WIDTH'(rx_data[3:0]);
  assign acc_a = opa * WIDTH'(10) + digit;
  assign acc_b = opb * WIDTH'(10) + digit;
  assign sum   = {1'b0, opa} + {1'b0, opb};
  assign diff  = opa - opb;
  assign prod  = {{WIDTH{1'b0}}, opa} * {{WIDTH{1'b0}}, opb};

  always_comb begin
    op_in = OpMul;
    if (rx_data == 8'h2B) op_in = OpAdd;
    else if (rx_data == 8'h2D) op_in = OpSub;
  end

  always_comb begin
    is_err = 1'b0;
    unique case (state)
      StIdle: is_err = !is_digit;
      StOpa:  is_err = !(is_op || (is_digit && room));
      StOpb0: is_err = !is_digit;
      StOpb:  is_err = !(is_term || (is_digit && room));
      default: is_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= StIdle;
      op           <= OpAdd;
      opa          <= '0;
      opb          <= '0;
      dcnt         <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      ovf          <= 1'b0;
      err          <= 1'b0;
      busy         <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      ovf          <= 1'b0;
      err          <= 1'b0;
      // Spaces are transparent: no state or register changes at all.
      if (rx_valid && !is_space) begin
        if (is_err) begin
          err   <= 1'b1;
          state <= StIdle;
          busy  <= 1'b0;
          op    <= OpAdd;
          opa   <= '0;
          opb   <= '0;
          dcnt  <= '0;
        end else begin
          unique case (state)
            StIdle: begin
              opa   <= digit;
              dcnt  <= CW'(1);
              state <= StOpa;
              busy  <= 1'b1;
            end
            StOpa: begin
              if (is_digit) begin
                opa  <= acc_a;
                dcnt <= dcnt + CW'(1);
              end else begin
                op    <= op_in;
                state <= StOpb0;
              end
            end
            StOpb0: begin
              opb   <= digit;
              dcnt  <= CW'(1);
              state <= StOpb;
            end
            StOpb: begin
              if (is_digit) begin
                opb  <= acc_b;
                dcnt <= dcnt + CW'(1);
              end else begin
                result_valid <= 1'b1;
                case (op)
                  OpAdd: begin
                    result <= sum[WIDTH-1:0];
                    ovf    <= sum[WIDTH];
                  end
                  OpSub: result <= diff;
                  default: begin
                    result <= prod[WIDTH-1:0];
                    ovf    <= |prod[2*WIDTH-1:WIDTH];
                  end
                endcase
                state <= StIdle;
                busy  <= 1'b0;
                op    <= OpAdd;
                opa   <= '0;
                opb   <= '0;
                dcnt  <= '0;
              end
            end
            default: state <= StIdle;
          endcase
        end
      end
    end
  end

endmodule
